// File: rtl/treeval_cmd_queue.sv
// Command queue in front of the tree-evaluation controller.
// Run commands stall issue until the controller reports a fresh result.
module treeval_cmd_queue #(
  parameter int DEPTH    = 8,
  parameter int W_REWARD = 10,
  parameter int W_ACTION = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_wr_en,
  input  logic [63:0]                sw_cmd,
  output logic                       sw_full,
  output logic [$clog2(DEPTH):0]     sw_count,
  output logic [63:0]                ctl_command,
  output logic                       ctl_cmd_valid,
  input  logic                       ctl_cmd_ready,
  input  logic signed [W_REWARD-1:0] ctl_exp,
  input  logic [W_ACTION-1:0]        ctl_act,
  input  logic                       ctl_done,
  output logic signed [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0]        res_act,
  output logic                       irq,
  input  logic                       irq_clr,
  output logic                       err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0]    CMD_RUN   = 2'd0;
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_EMPTY = '0;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  function automatic logic [1:0] cmd_type(input logic [63:0] cmd);
    return cmd[63:62];
  endfunction

  logic [63:0]         r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  state_t              r_state;
  logic                r_done_q;
  logic signed [W_REWARD-1:0] r_res_exp;
  logic [W_ACTION-1:0] r_res_act;
  logic                r_irq;
  logic                r_err_overflow;

  state_t              w_state_nxt;
  logic                w_capture;
  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_not_empty;
  logic [AW-1:0]       w_last;
  logic [63:0]         w_head;

  assign w_not_empty = (r_count != CNT_EMPTY);
  assign w_valid     = (r_state == ST_ISSUE) && w_not_empty;
  assign w_pop       = w_valid && ctl_cmd_ready;
  assign w_push      = sw_wr_en && ((r_count != CNT_FULL) || w_pop);
  assign w_drop      = sw_wr_en && (r_count == CNT_FULL) && !w_pop;
  // When empty, present the most recently written slot so the bus stays stable.
  assign w_last      = r_wptr - AW'(1);
  assign w_head      = w_not_empty ? r_mem[r_rptr] : r_mem[w_last];

  // Next-state and result-capture decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (w_pop && (cmd_type(w_head) == CMD_RUN)) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (ctl_done && !r_done_q) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_ISSUE;
      end
    endcase
  end

  // State register and ctl_done edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ISSUE;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= ctl_done;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= sw_cmd;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Results, completion interrupt (set beats clear) and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_exp      <= '0;
      r_res_act      <= '0;
      r_irq          <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_res_exp <= ctl_exp;
        r_res_act <= ctl_act;
        r_irq     <= 1'b1;
      end else if (irq_clr) begin
        r_irq <= 1'b0;
      end
      if (w_drop) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign sw_full       = (r_count == CNT_FULL);
  assign sw_count      = r_count;
  assign ctl_command   = w_head;
  assign ctl_cmd_valid = w_valid;
  assign res_exp       = r_res_exp;
  assign res_act       = r_res_act;
  assign irq           = r_irq;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_treeval_cmd_queue.sv
// Directed bench for treeval_cmd_queue: inputs change and outputs are
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_treeval_cmd_queue;

  logic              clk = 1'b0;
  logic              rst;
  logic              sw_wr_en;
  logic [63:0]       sw_cmd;
  logic              sw_full;
  logic [3:0]        sw_count;
  logic [63:0]       ctl_command;
  logic              ctl_cmd_valid;
  logic              ctl_cmd_ready;
  logic signed [9:0] ctl_exp;
  logic [2:0]        ctl_act;
  logic              ctl_done;
  logic signed [9:0] res_exp;
  logic [2:0]        res_act;
  logic              irq;
  logic              irq_clr;
  logic              err_overflow;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] RUN_CMD  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NODE_CMD = 64'h4000_0000_0000_0005;
  localparam logic [63:0] CFG_CMD  = 64'h8000_0000_0000_0033;

  treeval_cmd_queue dut (
    .clk(clk), .rst(rst), .sw_wr_en(sw_wr_en), .sw_cmd(sw_cmd),
    .sw_full(sw_full), .sw_count(sw_count), .ctl_command(ctl_command),
    .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready),
    .ctl_exp(ctl_exp), .ctl_act(ctl_act), .ctl_done(ctl_done),
    .res_exp(res_exp), .res_act(res_act), .irq(irq), .irq_clr(irq_clr),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; sw_wr_en = 1'b0; sw_cmd = 64'd0; ctl_cmd_ready = 1'b0;
    ctl_exp = 10'sd0; ctl_act = 3'd0; ctl_done = 1'b0; irq_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (sw_count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", sw_count); end
    n_vec++; if (sw_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b exp 0", sw_full); end
    n_vec++; if (ctl_cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", ctl_cmd_valid); end
    n_vec++; if (irq !== 1'b0 || err_overflow !== 1'b0) begin n_err++; $display("FAIL rst_flags got irq=%b err=%b exp 0/0", irq, err_overflow); end
    n_vec++; if (res_exp !== 10'sd0 || res_act !== 3'd0) begin n_err++; $display("FAIL rst_res got %0d/%0d exp 0/0", res_exp, res_act); end
    // first push right after release
    rst = 1'b0; sw_wr_en = 1'b1; sw_cmd = NODE_CMD;
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (sw_count !== 4'd1) begin n_err++; $display("FAIL first_push_count got %0d exp 1", sw_count); end
    ctl_cmd_ready = 1'b1;
    @(negedge clk); ctl_cmd_ready = 1'b0;
    n_vec++; if (sw_count !== 4'd0) begin n_err++; $display("FAIL first_push_drain got %0d exp 0", sw_count); end
  endtask

  task automatic test_in_order();
    @(negedge clk); sw_wr_en = 1'b1; sw_cmd = NODE_CMD;
    n_vec++; if (ctl_cmd_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got %b exp 0", ctl_cmd_valid); end
    @(negedge clk); sw_cmd = CFG_CMD; ctl_cmd_ready = 1'b1;
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== NODE_CMD) begin n_err++; $display("FAIL order_first got v=%b %h exp 1 %h", ctl_cmd_valid, ctl_command, NODE_CMD); end
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== CFG_CMD || sw_count !== 4'd1) begin n_err++; $display("FAIL order_second got v=%b %h cnt=%0d exp 1 %h 1", ctl_cmd_valid, ctl_command, sw_count, CFG_CMD); end
    @(negedge clk); ctl_cmd_ready = 1'b0;
    n_vec++; if (sw_count !== 4'd0 || ctl_cmd_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL order_end got cnt=%0d v=%b irq=%b exp 0 0 0", sw_count, ctl_cmd_valid, irq); end
  endtask

  task automatic test_run();
    @(negedge clk); ctl_cmd_ready = 1'b1; sw_wr_en = 1'b1; sw_cmd = RUN_CMD;
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== RUN_CMD) begin n_err++; $display("FAIL run_issue got v=%b %h exp 1 0", ctl_cmd_valid, ctl_command); end
    @(negedge clk); sw_wr_en = 1'b1; sw_cmd = NODE_CMD;
    n_vec++; if (ctl_cmd_valid !== 1'b0 || sw_count !== 4'd0) begin n_err++; $display("FAIL run_wait got v=%b cnt=%0d exp 0 0", ctl_cmd_valid, sw_count); end
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (sw_count !== 4'd1 || ctl_cmd_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL wait_push got cnt=%0d v=%b irq=%b exp 1 0 0", sw_count, ctl_cmd_valid, irq); end
    ctl_exp = -10'sd3; ctl_act = 3'd5; ctl_done = 1'b1;
    @(negedge clk); ctl_done = 1'b0; irq_clr = 1'b1; ctl_exp = 10'sd0; ctl_act = 3'd0;
    n_vec++; if (res_exp !== -10'sd3 || res_act !== 3'd5) begin n_err++; $display("FAIL run_capture got %0d/%0d exp -3/5", res_exp, res_act); end
    n_vec++; if (irq !== 1'b1 || ctl_cmd_valid !== 1'b1 || ctl_command !== NODE_CMD) begin n_err++; $display("FAIL run_resume got irq=%b v=%b %h exp 1 1 %h", irq, ctl_cmd_valid, ctl_command, NODE_CMD); end
    @(negedge clk); irq_clr = 1'b0; ctl_cmd_ready = 1'b0;
    n_vec++; if (irq !== 1'b0 || sw_count !== 4'd0) begin n_err++; $display("FAIL irq_clear got irq=%b cnt=%0d exp 0 0", irq, sw_count); end
    n_vec++; if (res_exp !== -10'sd3 || res_act !== 3'd5) begin n_err++; $display("FAIL res_hold got %0d/%0d exp -3/5", res_exp, res_act); end
  endtask

  task automatic test_full_push();
    logic [63:0] base;
    base = 64'h4000_0000_0000_0200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); sw_wr_en = 1'b1; sw_cmd = base + 64'(i);
    end
    @(negedge clk); sw_cmd = base + 64'd8; ctl_cmd_ready = 1'b1;
    n_vec++; if (sw_full !== 1'b1 || ctl_command !== base) begin n_err++; $display("FAIL full_head got full=%b %h exp 1 %h", sw_full, ctl_command, base); end
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (sw_count !== 4'd8 || sw_full !== 1'b1 || err_overflow !== 1'b0) begin n_err++; $display("FAIL full_pushpop got cnt=%0d full=%b err=%b exp 8 1 0", sw_count, sw_full, err_overflow); end
    for (int i = 1; i <= 8; i++) begin
      n_vec++; if (ctl_command !== base + 64'(i)) begin n_err++; $display("FAIL full_drain%0d got %h exp %h", i, ctl_command, base + 64'(i)); end
      @(negedge clk);
    end
    ctl_cmd_ready = 1'b0;
    n_vec++; if (sw_count !== 4'd0 || ctl_cmd_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got cnt=%0d v=%b exp 0 0", sw_count, ctl_cmd_valid); end
  endtask

  task automatic test_overflow();
    logic [63:0] base;
    base = 64'h4000_0000_0000_0100;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) begin
        n_vec++; if (sw_full !== 1'b1 || err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at8 got full=%b err=%b exp 1 0", sw_full, err_overflow); end
        n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== base) begin n_err++; $display("FAIL hold_stable got v=%b %h exp 1 %h", ctl_cmd_valid, ctl_command, base); end
      end
      sw_wr_en = 1'b1; sw_cmd = base + 64'(i);
    end
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (sw_count !== 4'd8 || err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got cnt=%0d err=%b exp 8 1", sw_count, err_overflow); end
    ctl_cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (ctl_command !== base + 64'(i)) begin n_err++; $display("FAIL ovf_drain%0d got %h exp %h", i, ctl_command, base + 64'(i)); end
      @(negedge clk);
    end
    ctl_cmd_ready = 1'b0;
    n_vec++; if (sw_count !== 4'd0 || ctl_cmd_valid !== 1'b0 || err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_ninth got cnt=%0d v=%b err=%b exp 0 0 1", sw_count, ctl_cmd_valid, err_overflow); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_rst got %b exp 0", err_overflow); end
  endtask

  task automatic test_done_held();
    @(negedge clk); ctl_done = 1'b1; ctl_cmd_ready = 1'b1; sw_wr_en = 1'b1; sw_cmd = RUN_CMD;
    @(negedge clk); sw_cmd = NODE_CMD;
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== RUN_CMD) begin n_err++; $display("FAIL held_issue got v=%b %h exp 1 0", ctl_cmd_valid, ctl_command); end
    @(negedge clk); sw_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (ctl_cmd_valid !== 1'b0 || irq !== 1'b0 || sw_count !== 4'd1) begin n_err++; $display("FAIL held_stay got v=%b irq=%b cnt=%0d exp 0 0 1", ctl_cmd_valid, irq, sw_count); end
    ctl_done = 1'b0;
    @(negedge clk); ctl_done = 1'b1; irq_clr = 1'b1; ctl_exp = 10'sd7; ctl_act = 3'd2;
    n_vec++; if (ctl_cmd_valid !== 1'b0) begin n_err++; $display("FAIL held_low got v=%b exp 0", ctl_cmd_valid); end
    @(negedge clk); ctl_done = 1'b0;
    n_vec++; if (irq !== 1'b1 || res_exp !== 10'sd7 || res_act !== 3'd2) begin n_err++; $display("FAIL set_wins got irq=%b %0d/%0d exp 1 7/2", irq, res_exp, res_act); end
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== NODE_CMD) begin n_err++; $display("FAIL held_resume got v=%b %h exp 1 %h", ctl_cmd_valid, ctl_command, NODE_CMD); end
    @(negedge clk); irq_clr = 1'b0; ctl_cmd_ready = 1'b0;
    n_vec++; if (irq !== 1'b0 || sw_count !== 4'd0) begin n_err++; $display("FAIL held_clear got irq=%b cnt=%0d exp 0 0", irq, sw_count); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); ctl_cmd_ready = 1'b1; sw_wr_en = 1'b1; sw_cmd = RUN_CMD;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); sw_cmd = 64'h4000_0000_0000_0300 + 64'(i);
    end
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (sw_count !== 4'd3 || ctl_cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_wait got cnt=%0d v=%b exp 3 0", sw_count, ctl_cmd_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (sw_count !== 4'd0 || ctl_cmd_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL async_rst got cnt=%0d v=%b irq=%b exp 0 0 0", sw_count, ctl_cmd_valid, irq); end
    @(negedge clk); rst = 1'b0; ctl_done = 1'b1; ctl_exp = 10'sd1; ctl_act = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (ctl_cmd_valid !== 1'b0 || sw_count !== 4'd0 || irq !== 1'b0 || res_exp !== 10'sd0) begin n_err++; $display("FAIL post_rst%0d got v=%b cnt=%0d irq=%b exp=%0d exp 0 0 0 0", i, ctl_cmd_valid, sw_count, irq, res_exp); end
    end
    ctl_done = 1'b0; sw_wr_en = 1'b1; sw_cmd = 64'h4000_0000_0000_0304;
    @(negedge clk); sw_wr_en = 1'b0;
    n_vec++; if (ctl_cmd_valid !== 1'b1 || ctl_command !== 64'h4000_0000_0000_0304) begin n_err++; $display("FAIL post_rst_push got v=%b %h exp 1 4000000000000304", ctl_cmd_valid, ctl_command); end
    @(negedge clk); ctl_cmd_ready = 1'b0;
    n_vec++; if (sw_count !== 4'd0) begin n_err++; $display("FAIL post_rst_drain got %0d exp 0", sw_count); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_run();
    test_full_push();
    test_overflow();
    test_done_held();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
